// File: rtl/format_decode_arbiter.sv
// -----------------------------------------------------------------------------
// format_decode_arbiter
//
// Two-thread front-end scheduler in front of a single instruction format
// decoder. Each thread buffers fetched instructions in a private FIFO. Every
// unstalled cycle one buffered entry is picked round-robin, dequeued, and
// loaded into a registered opcode/payload/address/format-class bundle tagged
// with its thread ID.
//
// Ports
//   clock_i, reset_i                 clock, synchronous active-high reset
//   tXEnable_i                       thread X input valid
//   tXInstruction_i                  thread X instruction word
//   tXAddress_i                      thread X instruction address
//   tXFormatClass_i                  thread X format class (0 = invalid)
//   tXFlush_i                        discard everything held for thread X
//   tXReady_o                        thread X FIFO not full
//   stall_i                          decoder back-pressure; hold outputs
//   enable_o                         output bundle valid
//   opCode_o / payload_o             instruction split, MSB-first numbering
//   address_o                        address of the issued instruction
//   instructionFormatClass_o         format class of the issued instruction
//   threadId_o                       0 = thread 0, 1 = thread 1
//   invalidFormat_o                  pulse: class-0 entry was dropped
//
// Build option
//   FORMAT_DROP_INVALID_EN  when defined, class-0 entries are consumed but not
//                           issued, and invalidFormat_o pulses instead. When
//                           undefined, they issue normally and invalidFormat_o
//                           is tied to 0.
// -----------------------------------------------------------------------------
module format_decode_arbiter #(
  parameter int instructionWidth = 32,
  parameter int addressSize      = 64,
  parameter int formatIndexRange = 5,
  parameter int opcodeWidth      = 6,
  parameter int fifoDepth        = 4
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic                                t0Enable_i,
  input  logic [instructionWidth-1:0]         t0Instruction_i,
  input  logic [addressSize-1:0]              t0Address_i,
  input  logic [formatIndexRange-1:0]         t0FormatClass_i,
  input  logic                                t0Flush_i,
  output logic                                t0Ready_o,
  input  logic                                t1Enable_i,
  input  logic [instructionWidth-1:0]         t1Instruction_i,
  input  logic [addressSize-1:0]              t1Address_i,
  input  logic [formatIndexRange-1:0]         t1FormatClass_i,
  input  logic                                t1Flush_i,
  output logic                                t1Ready_o,
  input  logic                                stall_i,
  output logic                                enable_o,
  output logic [opcodeWidth-1:0]              opCode_o,
  output logic [instructionWidth-opcodeWidth-1:0] payload_o,
  output logic [addressSize-1:0]              address_o,
  output logic [formatIndexRange-1:0]         instructionFormatClass_o,
  output logic                                threadId_o,
  output logic                                invalidFormat_o
);

  localparam int PW = $clog2(fifoDepth);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [instructionWidth-1:0] instr;
    logic [addressSize-1:0]      addr;
    logic [formatIndexRange-1:0] fclass;
  } entry_t;

  // Per-thread views of the two input ports so the FIFO logic is written once.
  entry_t     in_entry [2];
  logic [1:0] in_en;
  logic [1:0] flush;

  always_comb begin
    in_entry[0] = '{instr: t0Instruction_i, addr: t0Address_i, fclass: t0FormatClass_i};
    in_entry[1] = '{instr: t1Instruction_i, addr: t1Address_i, fclass: t1FormatClass_i};
    in_en       = {t1Enable_i, t0Enable_i};
    flush       = {t1Flush_i, t0Flush_i};
  end

  // FIFO state
  entry_t        mem    [2][fifoDepth];
  logic [PW-1:0] wr_ptr [2];
  logic [PW-1:0] rd_ptr [2];
  logic [CW-1:0] count  [2];

  // Output / arbitration state
  logic   ready_q;      // low while reset is held so Ready reads 0 in reset
  logic   last_grant;
  logic   enable_q;
  logic   thread_q;
  entry_t out_q;

  // Arbitration signals
  logic [1:0] ready;
  logic [1:0] avail;
  logic [1:0] enq;
  logic [1:0] deq;
  logic       grant_valid;
  logic       grant_tid;
  entry_t     head;

  assign ready[0] = ready_q && (count[0] != CW'(fifoDepth));
  assign ready[1] = ready_q && (count[1] != CW'(fifoDepth));

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    avail       = '0;
    enq         = '0;
    deq         = '0;
    grant_valid = 1'b0;
    grant_tid   = 1'b0;

    for (int t = 0; t < 2; t++) begin
      // A thread being flushed this cycle is never eligible for a grant.
      avail[t] = (count[t] != '0) && !flush[t];
      enq[t]   = in_en[t] && ready[t];
    end

    if (!stall_i) begin
      if (avail[0] && avail[1]) begin
        grant_valid = 1'b1;
        grant_tid   = ~last_grant;
      end else if (avail[0]) begin
        grant_valid = 1'b1;
        grant_tid   = 1'b0;
      end else if (avail[1]) begin
        grant_valid = 1'b1;
        grant_tid   = 1'b1;
      end
    end

    if (grant_valid) deq[grant_tid] = 1'b1;
    head = mem[grant_tid][rd_ptr[grant_tid]];
  end

  // NOTE: the storage array has no reset; the pointers and counts define which
  // entries are live, so clearing the data itself would only cost flops.
  always_ff @(posedge clock_i) begin
    for (int t = 0; t < 2; t++) begin
      if (enq[t] && !flush[t]) mem[t][wr_ptr[t]] <= in_entry[t];
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock_i) begin
    for (int t = 0; t < 2; t++) begin
      if (reset_i || flush[t]) begin
        // Flush wins over a same-cycle enqueue on the same thread.
        wr_ptr[t] <= '0;
        rd_ptr[t] <= '0;
        count[t]  <= '0;
      end else begin
        if (enq[t]) wr_ptr[t] <= wr_ptr[t] + PW'(1);
        if (deq[t]) rd_ptr[t] <= rd_ptr[t] + PW'(1);
        count[t] <= count[t] + CW'(enq[t]) - CW'(deq[t]);
      end
    end
  end

`ifdef FORMAT_DROP_INVALID_EN
  logic invalid_q;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ready_q    <= 1'b0;
      last_grant <= 1'b1;     // thread 0 wins the first tie after reset
      enable_q   <= 1'b0;
      thread_q   <= 1'b0;
      out_q      <= '0;
`ifdef FORMAT_DROP_INVALID_EN
      invalid_q  <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b1;
`ifdef FORMAT_DROP_INVALID_EN
      invalid_q <= 1'b0;
`endif
      if (!stall_i) begin
        if (grant_valid) begin
          out_q      <= head;
          thread_q   <= grant_tid;
          last_grant <= grant_tid;
`ifdef FORMAT_DROP_INVALID_EN
          // A class-0 entry still uses up this thread's turn.
          enable_q  <= (head.fclass != '0);
          invalid_q <= (head.fclass == '0);
`else
          enable_q  <= 1'b1;
`endif
        end else begin
          enable_q <= 1'b0;
        end
      end else if (enable_q && flush[thread_q]) begin
        // Stalled bundle belongs to a flushed thread: withdraw it.
        enable_q <= 1'b0;
      end
    end
  end

`ifdef FORMAT_DROP_INVALID_EN
  assign invalidFormat_o = invalid_q;
`else
  assign invalidFormat_o = 1'b0;
`endif

  // Bit 0 is the instruction MSB, so the opcode is the top field of the word.
  assign opCode_o                 = out_q.instr[instructionWidth-1 -: opcodeWidth];
  assign payload_o                = out_q.instr[instructionWidth-opcodeWidth-1:0];
  assign address_o                = out_q.addr;
  assign instructionFormatClass_o = out_q.fclass;
  assign enable_o                 = enable_q;
  assign threadId_o               = thread_q;
  assign t0Ready_o                = ready[0];
  assign t1Ready_o                = ready[1];

endmodule

// File: doc/format_decode_arbiter.md
# format_decode_arbiter

Two-thread front-end scheduler that shares the single instruction format decoder between two fetch streams. Each thread's fetched instructions are buffered in a private FIFO. Every cycle the block selects one buffered instruction by round-robin and presents it to the decoder as a registered opcode/payload/address/format-class bundle tagged with its thread ID. The block sits between fetch/format classification and the format decoder, and handles decoder back-pressure, per-thread flush and invalid-format filtering.

## Interface
- instructionWidth, 32, instruction word width
- addressSize, 64, instruction address width
- formatIndexRange, 5, format-class field width
- opcodeWidth, 6, primary opcode width (bits 0..opcodeWidth-1 of the instruction)
- fifoDepth, 4, entries per thread FIFO; power of two, ≥2
- clock_i  in  1  single clock, all state on rising edge
- reset_i  in  1  synchronous, active-high reset
- t0Enable_i / t1Enable_i  in  1  thread instruction valid
- t0Instruction_i / t1Instruction_i  in  instructionWidth  instruction word
- t0Address_i / t1Address_i  in  addressSize  instruction address
- t0FormatClass_i / t1FormatClass_i  in  formatIndexRange  format class, 0 = invalid
- t0Flush_i / t1Flush_i  in  1  discard all state held for that thread
- t0Ready_o / t1Ready_o  out  1  FIFO not full
- stall_i  in  1  decoder cannot accept; hold outputs
- enable_o  out  1  output bundle valid
- opCode_o  out  opcodeWidth  instruction bits [0:opcodeWidth-1]
- payload_o  out  instructionWidth-opcodeWidth  instruction bits [opcodeWidth:instructionWidth-1]
- address_o  out  addressSize  address of issued instruction
- instructionFormatClass_o  out  formatIndexRange  format class of issued instruction
- threadId_o  out  1  0 = thread 0, 1 = thread 1
- invalidFormat_o  out  1  one-cycle pulse: invalid-class entry dropped (macro only)

## Operation
- Enqueue: an input is written into its thread FIFO when tXEnable_i && tXReady_o. An input offered while tXReady_o=0 is ignored; the source must hold it.
- tXReady_o = (countX != fifoDepth). It derives from the registered count, so a FIFO that is full at the start of a cycle refuses input even if a dequeue happens in the same cycle.
- Occupancy per FIFO:
  - enqueue and dequeue in the same cycle leave the count unchanged.
  - pointers wrap modulo fifoDepth.
  - count width is log2(fifoDepth)+1.
- Arbitration is evaluated only when stall_i=0:
  - If both FIFOs are non-empty, grant the thread not granted last (lastGrant register).
  - If only one FIFO is non-empty, grant it.
  - If both are empty, enable_o <= 0.
  - lastGrant updates only on an actual grant.
- Grant: the FIFO head is dequeued and loaded into the output register. enable_o <= 1 and threadId_o <= granted thread.
- stall_i=1: the output register and all FIFO heads hold; nothing is dequeued. Enqueue still proceeds.
- Flush of thread X:
  - FIFO X is cleared (pointers and count to 0). Flush beats a same-cycle enqueue on X.
  - If the output register holds a thread-X entry, enable_o <= 0 next cycle, regardless of stall_i.
  - Thread X is not granted in the flush cycle.
- Reset clears both FIFOs and sets lastGrant=1, so thread 0 wins the first tie.
- Reset values: all outputs 0; t0Ready_o and t1Ready_o read 1 from the cycle after reset deasserts.

## Timing
- Minimum latency: an input captured at edge N appears with enable_o=1 after edge N+1 (two edges, FIFO write then output register).
- Throughput: one instruction per cycle total when stall_i=0. With both threads busy, the two threads alternate strictly.
- Outputs are registered with no combinational path from inputs to outputs, except tXReady_o, which derives from the registered count.
- Reset asserted mid-operation takes priority over all events on that edge. Any in-flight output is dropped.

## Configuration
- FORMAT_DROP_INVALID_EN defined:
  - An entry whose format class is 0 is dequeued when granted but is not issued: enable_o <= 0 and invalidFormat_o pulses 1 for one cycle, with threadId_o set to its thread.
  - This consumes that thread's round-robin turn.
- FORMAT_DROP_INVALID_EN undefined: class-0 entries are issued to the decoder like any other entry, and invalidFormat_o is tied to 0.

## Test plan
- Reset, then t0 sends instruction 0x38200010 at address 0x1000, class 3 → enable_o=1 two edges later, opCode_o=0x0E, address_o=0x1000, instructionFormatClass_o=3, threadId_o=0.
- Both threads send 4 entries back-to-back with no stall → threadId_o sequence 0,1,0,1,0,1,0,1 over 8 consecutive cycles.
- t0 sends 5 entries while stall_i=1 → t0Ready_o falls after the 4th; the 5th is held and not accepted. Release stall → all 5 issue in order.
- Entry 0x1000 from t1 is in the output register with stall_i=1, and t1Flush_i pulses → enable_o=0 next cycle, t1 FIFO empty, t1Ready_o=1. A t0 entry then issues once stall drops.
- With FORMAT_DROP_INVALID_EN, t0 sends class 0 then class 3 → invalidFormat_o pulses once with threadId_o=0; only the class-3 entry is issued with enable_o=1. Without the macro, both entries are issued.
- reset_i asserted with both FIFOs holding 3 entries → next cycle enable_o=0, both ready=1, first post-reset tie is granted to thread 0.
